hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32 core. It decides, every cycle, whether each pipeline register advances, holds or is flushed. It drives the PC update unit's `fstall`/`stop` inputs, resolves load-use, taken-branch and memory-wait hazards with a fixed priority, and supports a debug halt. A small FSM tracks multi-cycle data-memory waits and halt, and a watchdog flags instruction-fetch timeouts.

## Interface
- `IMEM_TIMEOUT`, 255: consecutive `imem_ready`=0 cycles after which `imem_err` sets; range 1..255, 8-bit counter.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rs1_d`, `rs2_d` input 5 each: source register indices of the instruction in ID.
- `rs1_used_d`, `rs2_used_d` input 1 each: the ID instruction actually reads that source.
- `rd_e` input 5: destination index of the instruction in EX.
- `mem_read_e` input 1: the EX instruction is a load.
- `branch_taken_e` input 1: the EX branch/jump resolved taken (`zero & branch` nonzero).
- `imem_ready` input 1: instruction fetch for the current PC completes this cycle.
- `dmem_req_m` input 1: the MEM instruction accesses data memory.
- `dmem_ready` input 1: data access completes this cycle.
- `dbg_halt` input 1: level request to halt.
- `dbg_resume` input 1: pulse that leaves HALT.
- `pc_stop` output 1: hold the PC (feeds PC unit `stop`).
- `stall_f` output 1: PC reloads its current value (feeds `fstall`).
- `stall_d`, `stall_e`, `stall_m` output 1 each: hold the IF/ID, ID/EX and EX/MEM registers.
- `flush_d`, `flush_e` output 1 each: load a bubble into IF/ID and ID/EX.
- `bubble_w` output 1: load a bubble into MEM/WB.
- `halted` output 1: FSM is in HALT.
- `imem_err` output 1: sticky fetch-timeout flag.

## Operation
- FSM states are RUN, DWAIT and HALT. All outputs are combinational from the state and the current inputs.
- Freeze condition: state is DWAIT or HALT, or in RUN `dmem_req_m && !dmem_ready`.
- Freeze response: `pc_stop`, `stall_d`, `stall_e` and `stall_m` are 1; `bubble_w` is 1; `flush_d` and `flush_e` are 0.
- Transition RUN→DWAIT: `dmem_req_m && !dmem_ready` and `dbg_halt`=0.
- Transition DWAIT→RUN: on `dmem_ready`=1. That cycle is still frozen; the MEM instruction completes and MEM/WB takes it (`bubble_w`=0 in that cycle).
- Transition RUN→HALT: `dbg_halt`=1 with no data access outstanding.
- `dbg_halt` during DWAIT: the FSM finishes DWAIT, then enters HALT.
- Transition HALT→RUN: on `dbg_resume`. `dbg_halt` is ignored in HALT.
- Branch (priority 2, RUN, not frozen): `branch_taken_e` gives `flush_d`=`flush_e`=1 and `stall_f`=0. The PC unit loads the target.
- Branch deferred by a freeze: EX is held, so `branch_taken_e` persists and the flush fires in the first unfrozen cycle.
- Load-use (priority 3): condition is `mem_read_e && rd_e!=0 && ((rs1_used_d && rs1_d==rd_e) || (rs2_used_d && rs2_d==rd_e))`.
  - Response: `stall_f`=`stall_d`=1 and `flush_e`=1, giving exactly one bubble.
  - Suppressed when `branch_taken_e`=1.
- Fetch wait (priority 4): `!imem_ready` gives `stall_f`=1 and `flush_d`=1. Downstream stages advance.
- Watchdog:
  - Counter increments each RUN cycle with `imem_ready`=0.
  - Counter clears on `imem_ready`=1.
  - Counter saturates at `IMEM_TIMEOUT`; reaching it sets `imem_err`.
  - `imem_err` clears only on `rst`.
  - The counter holds while frozen.
- Reset values:
  - State is RUN and the counter is 0.
  - `halted`=0 and `imem_err`=0.
  - While `rst`=1: `flush_d`=`flush_e`=`bubble_w`=1; every stall output and `pc_stop` is 0.
- Reset mid-DWAIT or mid-HALT returns to RUN in the next cycle.

## Timing
- Hazard outputs have zero latency: combinational from inputs within the same cycle.
- State, counter and `imem_err` update at the clock edge.
- `halted` goes high the cycle after the RUN→HALT decision and low the cycle after `dbg_resume`.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM, so the condition clears naturally.
- Taken branch penalty: 2 bubbles (IF/ID and ID/EX).
- `imem_err` goes high at the edge where the counter reaches `IMEM_TIMEOUT`, i.e. after 255 consecutive not-ready cycles by default.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- Defined: adds 32-bit outputs `perf_stall_cyc` (cycles with `stall_f` or `pc_stop` asserted), `perf_flush_cnt` (taken-branch flush events) and `perf_lu_cnt` (load-use bubbles).
  - All three are 0 on reset and wrap modulo 2^32.
  - None increments while `rst`=1.
- Undefined: the ports and counters are absent. Hazard behaviour is identical in both builds.

## Test plan
- Load-use: `mem_read_e`=1, `rd_e`=5, `rs1_d`=5, `rs1_used_d`=1 → one cycle with `stall_f`=`stall_d`=`flush_e`=1, then normal flow. Repeat with `rd_e`=0 → no stall.
- Branch vs load-use: `branch_taken_e`=1 with a load-use match in the same cycle → `flush_d`=`flush_e`=1, `stall_f`=0, no stall (`HAZARD_PERF_EN`: `perf_lu_cnt` unchanged).
- Data wait: `dmem_req_m`=1, `dmem_ready` low for 3 cycles, high on the 4th → 4 frozen cycles; `bubble_w`=1 in cycles 1-3 and 0 in cycle 4; back in RUN in cycle 5. A branch held in EX during the wait flushes in cycle 5.
- Halt: `dbg_halt` asserted during DWAIT → HALT entered only after `dmem_ready`; `halted`=1 until one cycle after `dbg_resume`.
- Watchdog: `IMEM_TIMEOUT`=4, `imem_ready`=0 for 4 cycles → `imem_err`=1 and sticky after `imem_ready` returns. A `rst` pulse clears it.
- Reset mid-HALT: `rst` for 1 cycle → state RUN, `halted`=0, flushes asserted during reset, all perf counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: per-stage stall, flush and bubble controls,
// data-wait/halt FSM and fetch watchdog. Optional perf counters under `HAZARD_PERF_EN`.
module hazard_ctrl #(
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic       rs1_used_d,
    input  logic       rs2_used_d,
    input  logic [4:0] rd_e,
    input  logic       mem_read_e,
    input  logic       branch_taken_e,
    input  logic       imem_ready,
    input  logic       dmem_req_m,
    input  logic       dmem_ready,
    input  logic       dbg_halt,
    input  logic       dbg_resume,
    output logic       pc_stop,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       bubble_w,
    output logic       halted,
    output logic       imem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_lu_cnt
`endif
);

    // state | meaning
    // RUN   | normal flow; a first-cycle data wait is frozen here
    // DWAIT | data access outstanding, pipeline frozen
    // HALT  | debug halt, pipeline frozen until dbg_resume
    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_e;

    localparam logic [7:0] TMO = 8'(IMEM_TIMEOUT);

    state_e     state_q;
    logic       halted_q;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       imem_err_q;

    logic dmem_wait;
    logic freeze;
    logic load_use;
    logic br_event;
    logic lu_event;

    always_comb begin
        dmem_wait = dmem_req_m && !dmem_ready;
        freeze    = (state_q != RUN) || dmem_wait;
        load_use  = mem_read_e && (rd_e != 5'd0) &&
                    ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));
        br_event  = !freeze && branch_taken_e;
        lu_event  = !freeze && !branch_taken_e && load_use;
    end

    always_comb begin
        pc_stop  = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        if (rst) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            bubble_w = 1'b1;
        end else if (freeze) begin
            pc_stop  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            // the completing access in DWAIT is handed to MEM/WB
            bubble_w = !((state_q == DWAIT) && dmem_ready);
        end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (!imem_ready) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!freeze) begin
            if (imem_ready) begin
                wd_cnt_d = 8'd0;
            end else if (wd_cnt_q < TMO) begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            halted_q   <= 1'b0;
            wd_cnt_q   <= 8'd0;
            imem_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_cnt_d == TMO) begin
                imem_err_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (dbg_halt && !dmem_wait) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (dmem_wait && !dbg_halt) begin
                        state_q <= DWAIT;
                    end
                end
                DWAIT: begin
                    // a halt requested during the wait is taken as the access completes
                    if (dmem_ready) begin
                        if (dbg_halt) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                HALT: begin
                    if (dbg_resume) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted   = halted_q;
    assign imem_err = imem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_lu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_lu_q    <= 32'd0;
        end else begin
            if (stall_f || pc_stop) perf_stall_q <= perf_stall_q + 32'd1;
            if (br_event)           perf_flush_q <= perf_flush_q + 32'd1;
            if (lu_event)           perf_lu_q    <= perf_lu_q + 32'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_lu_cnt    = perf_lu_q;
`else
    logic unused_events;
    assign unused_events = br_event ^ lu_event;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus multi-cycle
// sequences (load-use, data wait, halt, watchdog, reset mid-HALT).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_e;
    logic       rs1_used_d, rs2_used_d, mem_read_e, branch_taken_e;
    logic       imem_ready, dmem_req_m, dmem_ready, dbg_halt, dbg_resume;
    logic       pc_stop, stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, bubble_w, halted, imem_err;
    logic [7:0] outs;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.IMEM_TIMEOUT(4)) dut (
`ifdef HAZARD_PERF_EN
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_lu_cnt   (perf_lu_cnt),
`endif
        .clk           (clk),
        .rst           (rst),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rs1_used_d    (rs1_used_d),
        .rs2_used_d    (rs2_used_d),
        .rd_e          (rd_e),
        .mem_read_e    (mem_read_e),
        .branch_taken_e(branch_taken_e),
        .imem_ready    (imem_ready),
        .dmem_req_m    (dmem_req_m),
        .dmem_ready    (dmem_ready),
        .dbg_halt      (dbg_halt),
        .dbg_resume    (dbg_resume),
        .pc_stop       (pc_stop),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .bubble_w      (bubble_w),
        .halted        (halted),
        .imem_err      (imem_err)
    );

    // {pc_stop, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}
    assign outs = {pc_stop, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w};

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1u;
        logic       rs2u;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       ir;
        logic       dq;
        logic       dr;
        logic       dh;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rs1_d = 5'd0; rs2_d = 5'd0; rs1_used_d = 1'b0; rs2_used_d = 1'b0;
        rd_e = 5'd0; mem_read_e = 1'b0; branch_taken_e = 1'b0; imem_ready = 1'b1;
        dmem_req_m = 1'b0; dmem_ready = 1'b0; dbg_halt = 1'b0; dbg_resume = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        rd_e = r; rs1_d = r; rs1_used_d = 1'b1; mem_read_e = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        //            rst  rs1    rs2    u1   u2   rd     mr   br   ir   dq   dr   dh   exp
        vt[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h62};
        vt[2]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h62};
        vt[4]  = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06};
        vt[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06};
        vt[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vt[9]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h62};
        vt[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB9};
        vt[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        vt[12] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07};
        vt[13] = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB9};
        vt[14] = '{1'b0, 5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[15] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

        // reset
        idle();
        rst = 1'b1;
        #1;
        check("rst_outs", 32'(outs), 32'h07);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_err", 32'(imem_err), 32'd0);
        check("rst_idle_outs", 32'(outs), 32'h00);
`ifdef HAZARD_PERF_EN
        check("rst_perf", perf_stall_cyc | perf_flush_cnt | perf_lu_cnt, 32'd0);
`endif

        // combinational vectors in RUN; inputs return to idle before each edge
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = vt[i].rst; rs1_d = vt[i].rs1; rs2_d = vt[i].rs2;
            rs1_used_d = vt[i].rs1u; rs2_used_d = vt[i].rs2u; rd_e = vt[i].rd;
            mem_read_e = vt[i].mr; branch_taken_e = vt[i].br; imem_ready = vt[i].ir;
            dmem_req_m = vt[i].dq; dmem_ready = vt[i].dr; dbg_halt = vt[i].dh;
            #1;
            check($sformatf("vec%0d", i), 32'(outs), 32'(vt[i].exp));
            #1;
            idle();
        end

        // load-use: one stall cycle, then the load has left EX
        @(negedge clk);
        set_lu(5'd5);
        #1;
        check("lu_stall", 32'(outs), 32'h62);
        cyc();
        mem_read_e = 1'b0;
        #1;
        check("lu_clear", 32'(outs), 32'h00);
`ifdef HAZARD_PERF_EN
        check("perf_lu_1", perf_lu_cnt, 32'd1);
`endif

        // branch beats load-use
        idle();
        set_lu(5'd5);
        branch_taken_e = 1'b1;
        #1;
        check("br_lu_outs", 32'(outs), 32'h06);
        cyc();
`ifdef HAZARD_PERF_EN
        check("br_lu_perf_lu", perf_lu_cnt, 32'd1);
        check("br_lu_perf_flush", perf_flush_cnt, 32'd1);
`endif

        // data wait: 3 not-ready cycles, ready on the 4th, branch held in EX
        idle();
        dmem_req_m = 1'b1; branch_taken_e = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("dwait_c%0d", c), 32'(outs), 32'hB9);
            cyc();
        end
        dmem_ready = 1'b1;
        #1;
        check("dwait_c4", 32'(outs), 32'hB8);
        check("dwait_c4_halted", 32'(halted), 32'd0);
        cyc();
        dmem_req_m = 1'b0; dmem_ready = 1'b0;
        #1;
        check("dwait_c5_branch", 32'(outs), 32'h06);
        cyc();
`ifdef HAZARD_PERF_EN
        check("dwait_perf_flush", perf_flush_cnt, 32'd2);
`endif

        // halt requested during DWAIT, taken only once the access completes
        idle();
        dmem_req_m = 1'b1;
        cyc();
        dbg_halt = 1'b1;
        #1;
        check("halt_dwait_outs", 32'(outs), 32'hB9);
        cyc();
        check("halt_dwait_halted", 32'(halted), 32'd0);
        dmem_ready = 1'b1;
        #1;
        check("halt_ready_outs", 32'(outs), 32'hB8);
        cyc();
        dmem_req_m = 1'b0; dmem_ready = 1'b0;
        #1;
        check("halt_entered", 32'(halted), 32'd1);
        check("halt_outs", 32'(outs), 32'hB9);
        dbg_halt = 1'b0; dbg_resume = 1'b1;
        #1;
        check("halt_resume_cycle", 32'(halted), 32'd1);
        cyc();
        dbg_resume = 1'b0;
        #1;
        check("halt_left", 32'(halted), 32'd0);
        check("halt_left_outs", 32'(outs), 32'h00);

        // watchdog (timeout 4): clears on ready, sets on 4th consecutive miss, sticky
        idle();
        imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        check("wd_three", 32'(imem_err), 32'd0);
        cyc();
        check("wd_four", 32'(imem_err), 32'd1);
        imem_ready = 1'b1;
        cyc();
        cyc();
        check("wd_sticky", 32'(imem_err), 32'd1);

        // reset mid-HALT
        dbg_halt = 1'b1;
        cyc();
        dbg_halt = 1'b0;
        #1;
        check("rh_halted", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        check("rh_rst_outs", 32'(outs), 32'h07);
        cyc();
        rst = 1'b0;
        #1;
        check("rh_halted_clr", 32'(halted), 32'd0);
        check("rh_err_clr", 32'(imem_err), 32'd0);
        check("rh_outs", 32'(outs), 32'h00);
`ifdef HAZARD_PERF_EN
        check("rh_perf", perf_stall_cyc | perf_flush_cnt | perf_lu_cnt, 32'd0);
`endif
        cyc();
        check("rh_run_outs", 32'(outs), 32'h00);
        check("rh_run_halted", 32'(halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
